fb_wr_arbiter: RTL and testbench
================================

// Module: fb_wr_arbiter
// PURPOSE
//  Shares the single frame-buffer write port of the VGA pipeline between two game-logic requesters.
//  Requester A is the paddle/left updater; requester B is the ball/right updater.
//  Grants are round-robin, and each grant is a burst capped at MAX_BURST words.
//  Writes are gated to vertical blanking (vblank), so the VGA scan-out never sees a half-updated frame.
//  Sits between the game FSMs and the frame-buffer RAM write side; the scan-out read side is untouched.
// PARAMETERS
//  AW         15  frame-buffer address width (160x120 = 19200 words)
//  DW         3   pixel data width (R,G,B, 1 bit each)
//  MAX_BURST  16  max words acked per grant before re-arbitration (>=1)
// PORTS
//  clk        in   1   pixel/system clock
//  rst        in   1   synchronous reset, active-high
//  vblank     in   1   high while scan-out is in vertical blanking; writes allowed only then
//  req_a      in   1   requester A has a word pending
//  addr_a     in   AW  A write address, stable while req_a && !ack_a
//  data_a     in   DW  A write data, stable while req_a && !ack_a
//  ack_a      out  1   A word accepted this cycle (combinational)
//  req_b/addr_b/data_b/ack_b   same as A, for requester B
//  fb_we      out  1   frame-buffer write enable (registered)
//  fb_addr    out  AW  frame-buffer write address (registered)
//  fb_data    out  DW  frame-buffer write data (registered)
//  busy       out  1   high when state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - fb_we=0, fb_addr=0, fb_data=0; state=IDLE; burst_cnt=0; last_srv=B, so A wins the first tie.
//    - Any in-flight word is dropped.
//    - ack_a and ack_b are 0 while rst=1.
//  - FSM states: IDLE, GNT_A, GNT_B.
//  - IDLE:
//    - If vblank && (req_a || req_b), go to GNT_x next cycle.
//    - If only one requester is active, grant it.
//    - If both are active, grant the one != last_srv.
//    - burst_cnt <= 0. No ack is issued in IDLE.
//  - GNT_x:
//    - ack_x = req_x && vblank. On each ack, burst_cnt++.
//    - Exit to IDLE next cycle, with last_srv <= x, when any of these holds:
//      - !req_x;
//      - !vblank;
//      - ack with burst_cnt == MAX_BURST-1.
//  - Write latency: a word acked in cycle n appears on fb_we/fb_addr/fb_data in cycle n+1 for exactly one cycle.
//    fb_we=0 in every cycle not following an ack.
//  - Request-to-write latency: req raised in IDLE -> ack at +1 cycle -> fb_we at +2 cycles.
//  - Re-arbitration always costs exactly one IDLE cycle between bursts.
//  - Requester rule: present the next word in the cycle after ack. Deasserting req before ack is legal;
//    the word is simply not written.
//  - vblank falling mid-burst: no further ack; the word acked in the last vblank cycle is still written next cycle.
//    Unacked words stay pending at the requester.
//  - ack_a and ack_b are never high in the same cycle. At most one fb write per cycle.
//  - fb_addr is passed through unchanged; no range check (the caller guarantees addr < 19200).
// CONFIGURATION
//  - FB_ARB_STATS_EN defined:
//    - Adds out ports wcnt_a[15:0] and wcnt_b[15:0], registered words-acked-per-requester counters.
//    - Counters clear to 0 on rst and in the cycle after a vblank rising edge.
//    - They saturate at 16'hFFFF and otherwise increment on ack_x.
//  - FB_ARB_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. rst=1 for 3 cycles with req_a=req_b=1, vblank=1 -> ack_a=ack_b=0, fb_we=0, fb_addr=0, fb_data=0, busy=0.
//  2. vblank=1, req_a=1, addr_a=15'h0010, data_a=3'b101 for 1 word -> ack_a at t+1;
//     fb_we=1, fb_addr=15'h0010, fb_data=3'b101 at t+2; fb_we=0 at t+3.
//  3. MAX_BURST=4, vblank=1, req_a=req_b=1 held -> acks A,A,A,A, one idle cycle, B,B,B,B, idle, A...;
//     exactly 8 fb_we pulses per 10 cycles.
//  4. vblank=0, req_a=1 for 50 cycles -> no ack, fb_we=0 throughout; vblank rises at t -> ack_a at t+1.
//  5. vblank falls after 2 acks of a burst by A, with B also requesting ->
//     - the 2nd word is still written; no ack while vblank=0;
//     - at the next vblank B is granted first.
//  6. rst pulsed 1 cycle mid-burst (GNT_B) -> next cycle fb_we=0, busy=0;
//     after rst, with both requesting, A is granted first.
//  7. FB_ARB_STATS_EN: 5 A-writes + 3 B-writes in one vblank -> wcnt_a=5, wcnt_b=3;
//     both read 0 after the next vblank rising edge.

Source files
------------

// File: rtl/fb_wr_arbiter.sv
// Round-robin, vblank-gated arbiter sharing the frame-buffer write port between requesters A and B.
// Optional macro FB_ARB_STATS_EN adds saturating per-requester acked-word counters wcnt_a/wcnt_b.
module fb_wr_arbiter #(
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 3,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vblank,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          ack_b,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [DW-1:0] fb_data,
  output logic          busy
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]   wcnt_a,
  output logic [15:0]   wcnt_b
`endif
);

  localparam int unsigned    BCW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic           SRV_A      = 1'b0;
  localparam logic           SRV_B      = 1'b1;

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } fb_word_t;

  state_t         state, state_nxt;
  logic           last_srv, last_srv_nxt;
  logic [BCW-1:0] burst_cnt, burst_nxt;
  fb_word_t       word_sel;

  // State register plus the registered frame-buffer write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_srv  <= SRV_B;
      burst_cnt <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      state     <= state_nxt;
      last_srv  <= last_srv_nxt;
      burst_cnt <= burst_nxt;
      fb_we     <= ack_a | ack_b;
      if (ack_a | ack_b) begin
        fb_addr <= word_sel.addr;
        fb_data <= word_sel.data;
      end
    end
  end

  // Arbitration, burst accounting and acks; a burst ends on request drop, vblank end or cap
  always_comb begin
    state_nxt    = state;
    last_srv_nxt = last_srv;
    burst_nxt    = burst_cnt;
    ack_a        = 1'b0;
    ack_b        = 1'b0;
    unique case (state)
      IDLE: begin
        burst_nxt = '0;
        if (vblank && (req_a || req_b)) begin
          if (req_a && (!req_b || last_srv == SRV_B)) state_nxt = GNT_A;
          else                                        state_nxt = GNT_B;
        end
      end
      GNT_A: begin
        ack_a = req_a && vblank;
        if (ack_a) burst_nxt = burst_cnt + BCW'(1);
        if (!req_a || !vblank || (ack_a && burst_cnt == BURST_LAST)) begin
          state_nxt    = IDLE;
          last_srv_nxt = SRV_A;
        end
      end
      GNT_B: begin
        ack_b = req_b && vblank;
        if (ack_b) burst_nxt = burst_cnt + BCW'(1);
        if (!req_b || !vblank || (ack_b && burst_cnt == BURST_LAST)) begin
          state_nxt    = IDLE;
          last_srv_nxt = SRV_B;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      ack_a = 1'b0;
      ack_b = 1'b0;
    end
  end

  assign word_sel = ack_b ? fb_word_t'{addr: addr_b, data: data_b}
                          : fb_word_t'{addr: addr_a, data: data_a};
  assign busy     = (state != IDLE);

`ifdef FB_ARB_STATS_EN
  logic vblank_q;

  // Acked-word counters, cleared at the start of each vblank and saturating at 16'hFFFF
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_q <= 1'b0;
      wcnt_a   <= '0;
      wcnt_b   <= '0;
    end else begin
      vblank_q <= vblank;
      if (vblank && !vblank_q) begin
        wcnt_a <= '0;
        wcnt_b <= '0;
      end else begin
        if (ack_a && (wcnt_a != 16'hFFFF)) wcnt_a <= wcnt_a + 16'd1;
        if (ack_b && (wcnt_b != 16'hFFFF)) wcnt_b <= wcnt_b + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Randomized bench for fb_wr_arbiter (MAX_BURST=4) against a behavioural model, plus directed scenarios.
module tb_fb_wr_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 3;
  localparam int          MB = 4;

  logic          clk = 1'b0;
  logic          rst, vblank, req_a, req_b, ack_a, ack_b, fb_we, busy;
  logic [AW-1:0] addr_a, addr_b, fb_addr;
  logic [DW-1:0] data_a, data_b, fb_data;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   wcnt_a, wcnt_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_wr_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .vblank  (vblank),
    .req_a   (req_a),
    .addr_a  (addr_a),
    .data_a  (data_a),
    .ack_a   (ack_a),
    .req_b   (req_b),
    .addr_b  (addr_b),
    .data_b  (data_b),
    .ack_b   (ack_b),
    .fb_we   (fb_we),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .busy    (busy)
`ifdef FB_ARB_STATS_EN
    ,
    .wcnt_a  (wcnt_a),
    .wcnt_b  (wcnt_b)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner 0=none 1=A 2=B, words left in the current grant, tie priority
  int            m_owner  = 0;
  int            m_left   = 0;
  bit            m_prio_a = 1'b1;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_data   = '0;
  logic [15:0]   m_wa     = '0;
  logic [15:0]   m_wb     = '0;
  logic          m_vb_prev = 1'b0;

  always @(negedge clk) begin : model
    logic ea, eb, req_g;
    ea = !rst && (m_owner == 1) && req_a && vblank;
    eb = !rst && (m_owner == 2) && req_b && vblank;
    chk1("m_ack_a", ack_a, ea);
    chk1("m_ack_b", ack_b, eb);
    chk1("m_busy", busy, m_owner != 0);
    chk1("m_fb_we", fb_we, m_we);
    if (m_we) begin
      chkv("m_fb_addr", 32'(fb_addr), 32'(m_addr));
      chkv("m_fb_data", 32'(fb_data), 32'(m_data));
    end
`ifdef FB_ARB_STATS_EN
    chkv("m_wcnt_a", 32'(wcnt_a), 32'(m_wa));
    chkv("m_wcnt_b", 32'(wcnt_b), 32'(m_wb));
`endif
    if (rst) begin
      m_owner = 0; m_left = 0; m_prio_a = 1'b1;
      m_we = 1'b0; m_addr = '0; m_data = '0;
      m_wa = '0; m_wb = '0; m_vb_prev = 1'b0;
    end else begin
      m_we = ea | eb;
      if (ea) begin m_addr = addr_a; m_data = data_a; end
      else if (eb) begin m_addr = addr_b; m_data = data_b; end
      if (vblank && !m_vb_prev) begin
        m_wa = '0; m_wb = '0;
      end else begin
        if (ea && m_wa != 16'hFFFF) m_wa = m_wa + 16'd1;
        if (eb && m_wb != 16'hFFFF) m_wb = m_wb + 16'd1;
      end
      m_vb_prev = vblank;
      if (m_owner == 0) begin
        if (vblank && (req_a || req_b)) begin
          m_owner = (req_a && (!req_b || m_prio_a)) ? 1 : 2;
          m_left  = MB;
        end
      end else begin
        req_g = (m_owner == 1) ? req_a : req_b;
        if (ea || eb) m_left--;
        if (!req_g || !vblank || m_left == 0) begin
          m_prio_a = (m_owner == 2);
          m_owner  = 0;
        end
      end
    end
  end

  logic la = 1'b0;
  logic lb = 1'b0;

  task automatic mid();
    @(negedge clk);
  endtask

  // Record this cycle's acks, move to the next cycle and present the next word where one was taken
  task automatic adv();
    la = ack_a;
    lb = ack_b;
    @(posedge clk);
    #1;
    if (la) begin addr_a = addr_a + 15'd1; data_a = data_a + 3'd1; end
    if (lb) begin addr_b = addr_b + 15'd1; data_b = data_b + 3'd1; end
  endtask

  task automatic rnd_req(input logic acked, input logic r_in, input logic [AW-1:0] a_in,
                         input logic [DW-1:0] d_in, output logic r, output logic [AW-1:0] a,
                         output logic [DW-1:0] d);
    if (r_in && !acked) begin
      r = ($urandom_range(0, 7) != 0);
      a = a_in;
      d = d_in;
    end else begin
      r = ($urandom_range(0, 3) != 0);
      a = 15'($urandom);
      d = 3'($urandom);
    end
  endtask

  initial begin : stim
    string         pat;
    logic [AW-1:0] w2_addr;
    logic [DW-1:0] w2_data;
    int            nwe;
    rst = 1'b1; vblank = 1'b1; req_a = 1'b1; req_b = 1'b1;
    addr_a = 15'h0100; data_a = 3'd1; addr_b = 15'h0200; data_b = 3'd2;

    // Reset held with both requesting inside vblank
    for (int i = 0; i < 3; i++) begin
      mid();
      chk1("t1_ack_a", ack_a, 1'b0);
      chk1("t1_ack_b", ack_b, 1'b0);
      chk1("t1_fb_we", fb_we, 1'b0);
      chkv("t1_fb_addr", 32'(fb_addr), 32'h0);
      chkv("t1_fb_data", 32'(fb_data), 32'h0);
      chk1("t1_busy", busy, 1'b0);
      adv();
    end

    // Single word from A: ack at +1, write at +2, gone at +3
    rst = 1'b0; req_b = 1'b0; req_a = 1'b1; addr_a = 15'h0010; data_a = 3'b101;
    mid(); chk1("t2_ack_t0", ack_a, 1'b0); adv();
    mid(); chk1("t2_ack_t1", ack_a, 1'b1); adv();
    req_a = 1'b0;
    mid();
    chk1("t2_we_t2", fb_we, 1'b1);
    chkv("t2_addr_t2", 32'(fb_addr), 32'h10);
    chkv("t2_data_t2", 32'(fb_data), 32'h5);
    adv();
    mid(); chk1("t2_we_t3", fb_we, 1'b0); adv();

    // Both held: bursts of 4 with one idle cycle between
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    mid(); adv();
    rst = 1'b0;
    pat = "-AAAA-BBBB-AAAA-BBBB";
    nwe = 0;
    for (int i = 0; i < 20; i++) begin
      mid();
      chk1("t3_ack_a", ack_a, pat[i] == "A");
      chk1("t3_ack_b", ack_b, pat[i] == "B");
      if (i >= 1 && i <= 10 && fb_we) nwe++;
      adv();
    end
    chkv("t3_we_per10", 32'(nwe), 32'd8);

    // Outside vblank nothing is acked or written
    vblank = 1'b0; req_b = 1'b0; req_a = 1'b1;
    for (int i = 0; i < 50; i++) begin
      mid();
      chk1("t4_ack_a", ack_a, 1'b0);
      if (i > 0) chk1("t4_fb_we", fb_we, 1'b0);
      adv();
    end
    vblank = 1'b1; req_b = 1'b1;
    mid(); chk1("t4_ack_t", ack_a, 1'b0); adv();
    mid(); chk1("t4_ack_t1", ack_a, 1'b1); chk1("t5_ack_b1", ack_b, 1'b0); adv();

    // vblank falls after the 2nd word of A's burst; B goes first at the next vblank
    mid(); chk1("t5_ack2", ack_a, 1'b1); w2_addr = addr_a; w2_data = data_a; adv();
    vblank = 1'b0;
    mid();
    chk1("t5_noack_a", ack_a, 1'b0);
    chk1("t5_noack_b", ack_b, 1'b0);
    chk1("t5_we_w2", fb_we, 1'b1);
    chkv("t5_addr_w2", 32'(fb_addr), 32'(w2_addr));
    chkv("t5_data_w2", 32'(fb_data), 32'(w2_data));
    adv();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk1("t5_low_ack_a", ack_a, 1'b0);
      chk1("t5_low_ack_b", ack_b, 1'b0);
      chk1("t5_low_we", fb_we, 1'b0);
      adv();
    end
    vblank = 1'b1;
    mid(); chk1("t5_idle_ack_b", ack_b, 1'b0); adv();
    mid(); chk1("t5_b_first", ack_b, 1'b1); chk1("t5_a_waits", ack_a, 1'b0); adv();

    // Reset pulse in the middle of B's burst
    rst = 1'b1;
    mid(); chk1("t6_rst_ack_b", ack_b, 1'b0); chk1("t6_rst_ack_a", ack_a, 1'b0); adv();
    rst = 1'b0;
    mid(); chk1("t6_we", fb_we, 1'b0); chk1("t6_busy", busy, 1'b0); adv();
    mid(); chk1("t6_a_first", ack_a, 1'b1); chk1("t6_b_waits", ack_b, 1'b0); adv();

`ifdef FB_ARB_STATS_EN
    // 5 A-words and 3 B-words within one vblank, then cleared at the next vblank
    begin : stats
      int na, nb;
      na = 0; nb = 0;
      rst = 1'b1; vblank = 1'b0; req_a = 1'b0; req_b = 1'b0;
      mid(); adv();
      rst = 1'b0;
      mid(); adv();
      vblank = 1'b1; req_a = 1'b1;
      for (int i = 0; i < 40 && (na < 5 || nb < 3); i++) begin
        mid();
        if (ack_a) na++;
        if (ack_b) nb++;
        adv();
        req_a = (na < 5);
        req_b = (na >= 5) && (nb < 3);
      end
      chkv("t7_acks_a", 32'(na), 32'd5);
      chkv("t7_acks_b", 32'(nb), 32'd3);
      mid();
      chkv("t7_wcnt_a", 32'(wcnt_a), 32'd5);
      chkv("t7_wcnt_b", 32'(wcnt_b), 32'd3);
      adv();
      vblank = 1'b0;
      mid(); adv();
      mid(); adv();
      vblank = 1'b1;
      mid(); chkv("t7_hold_a", 32'(wcnt_a), 32'd5); adv();
      mid();
      chkv("t7_clr_a", 32'(wcnt_a), 32'd0);
      chkv("t7_clr_b", 32'(wcnt_b), 32'd0);
      adv();
    end
`endif

    // Randomized traffic obeying the requester rules, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      rnd_req(la, req_a, addr_a, data_a, req_a, addr_a, data_a);
      rnd_req(lb, req_b, addr_b, data_b, req_b, addr_b, data_b);
      mid();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
